// File: rtl/adder_pkg.sv
// Shared configuration for the pipelined adder.
// Holds the default operand width and pipeline depth, the segment-width
// derivation, and the legality rule applied by the top at elaboration.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 32;
  localparam int unsigned DEFAULT_STAGES = 4;

  // Width of one pipeline segment; guards against a zero stage count.
  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Legal configuration: at least one stage, equal non-empty segments.
  function automatic bit cfg_ok(input int unsigned width,
                                input int unsigned stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple adder used as one pipeline segment.
// Ports:
//   a, b       segment operand bits
//   cin        carry into the segment LSB
//   sum_c      segment sum bits
//   cout_c     carry out of the segment MSB
//   msb_cin_c  carry into the segment MSB (signed-overflow detection)
module adder_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum_c,
  output logic           cout_c,
  output logic           msb_cin_c
);

  // SEG+1 bit internal sum; the top bit is the segment carry.
  logic [SEG:0] total;

  assign total  = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);
  assign sum_c  = total[SEG-1:0];
  assign cout_c = total[SEG];

  // The carry into the MSB is recovered from the MSB sum bit.
  assign msb_cin_c = a[SEG-1] ^ b[SEG-1] ^ total[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder with valid/ready handshake on both sides.
// The WIDTH-bit addition is split into STAGES equal segments; each stage
// adds one segment and registers its carry, the partial sum so far and the
// operand bits still to be consumed. One result per cycle, STAGES latency.
// Optional feature macro: PIPELINED_ADDER_OVF_EN adds the registered signed
// overflow output ovf.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         operands on a, b, cin are valid
//   in_ready         operands accepted this cycle (combinational)
//   a, b, cin        operands and carry into bit 0
//   out_valid        sum/cout hold a result
//   out_ready        consumer takes the result this cycle
//   sum, cout        (a + b + cin) mod 2^WIDTH and carry out of MSB
//   ovf              signed overflow (only with PIPELINED_ADDER_OVF_EN)
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SEG   = seg_width(WIDTH, STAGES);
  // Registers between stage k and k+1; one dummy slot when STAGES is 1.
  localparam int unsigned NPIPE = (STAGES > 1) ? STAGES - 1 : 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Global advance: every stage moves together or holds together.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Inter-stage registers and their next values.
  logic             pv_q [NPIPE];
  logic             pc_q [NPIPE];
  logic [WIDTH-1:0] pa_q [NPIPE];
  logic [WIDTH-1:0] pb_q [NPIPE];
  logic [WIDTH-1:0] ps_q [NPIPE];

  logic             pv_d [NPIPE];
  logic             pc_d [NPIPE];
  logic [WIDTH-1:0] pa_d [NPIPE];
  logic [WIDTH-1:0] pb_d [NPIPE];
  logic [WIDTH-1:0] ps_d [NPIPE];

  // Final-stage results feeding the output registers.
  logic             last_v;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             msb_d;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic             seg_msb;
    logic [WIDTH-1:0] s_out;

    // Stage inputs: ports for stage 0, previous stage registers otherwise.
    if (k == 0) begin : g_first
      assign v_in = in_valid;
      assign c_in = cin;
      assign a_in = a;
      assign b_in = b;
      assign s_in = '0;
    end else begin : g_mid
      assign v_in = pv_q[k-1];
      assign c_in = pc_q[k-1];
      assign a_in = pa_q[k-1];
      assign b_in = pb_q[k-1];
      assign s_in = ps_q[k-1];
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a         (a_in[k*SEG +: SEG]),
      .b         (b_in[k*SEG +: SEG]),
      .cin       (c_in),
      .sum_c     (seg_sum),
      .cout_c    (seg_cout),
      .msb_cin_c (seg_msb)
    );

    // Segments above k are still zero in s_in, so OR inserts this segment.
    assign s_out = s_in | (WIDTH'(seg_sum) << (k*SEG));

    if (k == STAGES - 1) begin : g_last
      logic unused_ops;
      assign unused_ops = ^{a_in, b_in};
      assign last_v = v_in;
      assign sum_d  = s_out;
      assign cout_d = seg_cout;
`ifdef PIPELINED_ADDER_OVF_EN
      assign msb_d  = seg_msb;
`else
      logic unused_msb;
      assign unused_msb = seg_msb;
`endif
    end else begin : g_pass
      logic unused_msb;
      assign unused_msb = seg_msb;
      assign pv_d[k] = v_in;
      assign pc_d[k] = seg_cout;
      assign pa_d[k] = a_in;
      assign pb_d[k] = b_in;
      assign ps_d[k] = s_out;
    end
  end

  // Inter-stage registers; data only loads behind a valid entry.
  if (STAGES > 1) begin : g_pipe_regs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(NPIPE); i++) begin
          pv_q[i] <= 1'b0;
          pc_q[i] <= 1'b0;
          pa_q[i] <= '0;
          pb_q[i] <= '0;
          ps_q[i] <= '0;
        end
      end else if (adv) begin
        for (int i = 0; i < int'(NPIPE); i++) begin
          pv_q[i] <= pv_d[i];
          if (pv_d[i]) begin
            pc_q[i] <= pc_d[i];
            pa_q[i] <= pa_d[i];
            pb_q[i] <= pb_d[i];
            ps_q[i] <= ps_d[i];
          end
        end
      end
    end
  end

  // Output registers; sum/cout keep the last result across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (adv) begin
      out_valid <= last_v;
      if (last_v) begin
        sum  <= sum_d;
        cout <= cout_d;
      end
    end
  end

`ifdef PIPELINED_ADDER_OVF_EN
  // Signed overflow: carry into MSB differs from carry out of MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (adv && last_v) begin
      ovf <= msb_d ^ cout_d;
    end
  end
`endif

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined ripple-carry adder with a valid/ready handshake on both sides. Splits a WIDTH-bit addition into STAGES equal segments, registers the carry and the skewed operands between segments, and delivers one result per cycle at STAGES-cycle latency. Sits between operand producers and consumers in the datapath as the scalable, clocked successor to the single-bit `fulladder` cell.

## Interface
- `WIDTH`, 32: operand and sum width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth and segment count, ≥1. Segment width `SEG = WIDTH/STAGES`.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands on `a`, `b` and `cin` are valid.
- `in_ready`  output  1  block accepts operands this cycle.
- `a`  input  WIDTH  operand A, unsigned or two's complement.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry into bit 0.
- `out_valid`  output  1  `sum` and `cout` hold a result.
- `out_ready`  input  1  consumer takes the result this cycle.
- `sum`  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- `cout`  output  1  carry out of bit WIDTH-1.
- `ovf`  output  1  signed overflow; present only with `PIPELINED_ADDER_OVF_EN`.

## Operation
- Stage k (0..STAGES-1) adds bits [k·SEG +: SEG] of A and B, using the carry registered by stage k-1 (stage 0 uses `cin`).
- Stage k registers: its valid bit, its carry out, the sum segments completed so far, and the A/B bits for segments k+1..STAGES-1. Operand bits for a segment are therefore delayed k cycles before they are used.
- Global advance signal: `adv = !out_valid || out_ready`. All stage registers load only when `adv` is 1; otherwise every stage holds.
- `in_ready = adv`. A transfer occurs when `in_valid && in_ready`. Stage 0's valid bit loads `in_valid && adv`.
- Bubbles (invalid stages) move forward with the pipeline; they are not collapsed.
- Output transfer occurs when `out_valid && out_ready`. Results leave in acceptance order with no loss or duplication.
- Width rule: the internal segment sum is SEG+1 bits; bit SEG is the registered carry. `cout` is the final stage's carry.
- `sum` and `cout` are undefined-free: they hold their last loaded value while `out_valid` is 0.

## Timing
- Reset (asynchronous assertion, synchronous release edge): all valid bits, data registers, `sum`, `cout` and `ovf` are set to 0. `in_ready` reads 1 because `out_valid` is 0.
- Latency: an operand accepted on edge N appears with `out_valid=1` after edge N+STAGES-1, i.e. registered at the STAGES-th edge counting acceptance.
- Throughput: 1 result/cycle while `out_ready` is held at 1.
- Stall: `out_valid && !out_ready` deasserts `in_ready` in the same cycle (combinational path `out_ready`→`in_ready`), and all stages freeze.
- Simultaneous output consume and input accept in one cycle is permitted.
- Reset mid-operation discards all in-flight results. No partial output is produced.
- With `STAGES=1`, the block is a single registered adder with latency 1.

## Configuration
- `PIPELINED_ADDER_OVF_EN` defined: the `ovf` port exists. It equals carry-into-MSB XOR `cout`, registered alongside `cout`, and is reset to 0.
- Not defined: the `ovf` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `adder_pkg`: default `WIDTH`/`STAGES` constants and a `SEG` derivation function. It also holds the elaboration check that `WIDTH % STAGES == 0` and `STAGES ≥ 1`.
- One sub-module, `adder_segment`: combinational SEG-bit ripple adder (a, b, cin → sum, cout, carry-into-MSB), instantiated STAGES times.

## Test plan
- Reset: hold `rst_n=0` with `in_valid=1`. Expect `out_valid=0`, `sum=0`, `cout=0`, `in_ready=1`. Release reset and check that the first result appears after exactly STAGES edges.
- Basic (WIDTH=8, STAGES=2): a=0x0F, b=0x01, cin=0 → sum=0x10, cout=0, 2 cycles later. Then a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1 (carry crosses the segment boundary).
- Back-to-back: 16 consecutive random operand sets with `out_ready=1`. Expect 16 results on consecutive cycles, matching a reference model, in order.
- Backpressure: drop `out_ready` for 3 cycles mid-stream. Expect `in_ready=0` and all outputs stable during the stall, then no loss or duplicate when `out_ready` returns.
- Bubbles: alternate `in_valid` 1/0. Expect `out_valid` to alternate with the same pattern, delayed by STAGES cycles.
- Overflow (`PIPELINED_ADDER_OVF_EN`, WIDTH=8): 0x7F+0x01 → sum=0x80, ovf=1, cout=0. Then 0x80+0x80 → sum=0x00, ovf=1, cout=1. Then 0x10+0x20 → ovf=0.
